// File: rtl/pipe_stage_queue.sv
// Elastic pipeline stage: a DEPTH-entry FIFO with valid/ready on both sides,
// synchronous flush and optional fall-through when empty.
module pipe_stage_queue #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 2,
    parameter int FALLTHROUGH = 0,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic empty;
    logic push;
    logic pop;
    logic bypass;
    logic write;
    logic read;

    assign empty    = (count_reg == '0);
    assign in_ready = (count_reg != FULL_CNT);
    assign count    = count_reg;

    // Head is shown even during a flush; fall-through is killed by flush.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (!empty) begin
            out_valid = 1'b1;
            out_data  = mem[rd_ptr_reg];
        end else if ((FALLTHROUGH != 0) && in_valid && !flush) begin
            out_valid = 1'b1;
            out_data  = in_data;
        end
    end

    assign push   = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready & ~flush;
    // A pop while empty can only be a fall-through word consumed directly.
    assign bypass = pop & empty;
    assign write  = push & ~bypass;
    assign read   = pop & ~empty;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (write) begin
                wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (read) begin
                rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({write, read})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_reg <= FULL_CNT);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (pop && empty) |-> (FALLTHROUGH != 0));

endmodule

// File: tb/tb_pipe_stage_queue.sv
// Drives four differently configured queue instances with shared stimulus and
// checks each against its own queue-based reference model.
module tb_pipe_stage_queue;

    localparam int W    = 16;
    localparam int NDUT = 4;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 2;
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int ft_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         ir_w  [NDUT];
    logic         ov_w  [NDUT];
    logic [W-1:0] od_w  [NDUT];
    logic [3:0]   cnt_w [NDUT];

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [NDUT][$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int D  = dep_of(gi);
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        pipe_stage_queue #(
            .WIDTH(W),
            .DEPTH(D),
            .FALLTHROUGH(ft_of(gi))
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .flush(flush),
            .in_valid(in_valid),
            .in_ready(ir_w[gi]),
            .in_data(in_data),
            .out_valid(ov_w[gi]),
            .out_ready(out_ready),
            .out_data(od_w[gi]),
            .count(c)
        );
        assign cnt_w[gi] = 4'(c);
    end

    task automatic check(input string nm, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, i, $time, act, exp);
        end
    endtask

    // Monitor and reference model: compares combinational outputs mid-cycle,
    // then applies the transfers that the coming edge will perform.
    always @(negedge clk) begin
        int           sz;
        logic         exp_ir;
        logic         exp_ov;
        logic [W-1:0] exp_od;
        logic [W-1:0] dummy;
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                exp_q[i].delete();
                check("rst_count", i, 32'(cnt_w[i]), 32'd0);
                check("rst_out_valid", i, 32'(ov_w[i]), 32'd0);
                check("rst_in_ready", i, 32'(ir_w[i]), 32'd1);
                check("rst_out_data", i, 32'(od_w[i]), 32'd0);
            end else begin
                sz     = exp_q[i].size();
                exp_ir = (sz != dep_of(i));
                if (sz > 0) begin
                    exp_ov = 1'b1;
                    exp_od = exp_q[i][0];
                end else if (ft_of(i) != 0 && in_valid && !flush) begin
                    exp_ov = 1'b1;
                    exp_od = in_data;
                end else begin
                    exp_ov = 1'b0;
                    exp_od = '0;
                end
                check("count", i, 32'(cnt_w[i]), 32'(sz));
                check("in_ready", i, 32'(ir_w[i]), 32'(exp_ir));
                check("out_valid", i, 32'(ov_w[i]), 32'(exp_ov));
                check("out_data", i, 32'(od_w[i]), 32'(exp_od));
                if (flush) begin
                    exp_q[i].delete();
                end else begin
                    if (exp_ov && out_ready) begin
                        $display("dut%0d t=%0t pop data=%h", i, $time, exp_od);
                        if (sz > 0) dummy = exp_q[i].pop_front();
                    end
                    if (in_valid && exp_ir && !(sz == 0 && exp_ov && out_ready))
                        exp_q[i].push_back(in_data);
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-stream: outputs must clear before the next clock edge.
        drive(1'b1, 16'h0001, 1'b0, 1'b0);
        drive(1'b1, 16'h0002, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("async_rst_count", i, 32'(cnt_w[i]), 32'd0);
            check("async_rst_out_valid", i, 32'(ov_w[i]), 32'd0);
            check("async_rst_in_ready", i, 32'(ir_w[i]), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill under backpressure, refused push, then drain.
        drive(1'b1, 16'h000A, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        drive(1'b1, 16'h000C, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming 1..8.
        for (int k = 1; k <= 8; k++) drive(1'b1, W'(k), 1'b1, 1'b0);
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush with a concurrent push.
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        drive(1'b1, 16'h0033, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Fall-through bypass, then fall-through with backpressure.
        drive(1'b1, 16'h0005, 1'b1, 1'b0);
        drive(1'b1, 16'h0005, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush while empty must suppress fall-through.
        drive(1'b1, 16'h0077, 1'b1, 1'b1);

        // Random traffic exercising wrap and mixed push/pop.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        repeat (4) drive(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
